// File: rtl/axi4_bfm_pkg.sv
// Shared response codes, FSM encodings and a ceiling-log2 helper for the AXI4-Lite responder.
package axi4_bfm_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_COLLECT, W_RESP} wr_state_e;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axi4_mem_responder_if.sv
// AXI4-Lite bus bundle between initiator and responder.
// AXI4_MEM_RESPONDER_WSTRB_EN adds the wstrb byte-lane strobes.
interface axi4_mem_responder_if #(
    parameter int unsigned ADDRWIDTH = 32,
    parameter int unsigned DATAWIDTH = 32
);
    logic [ADDRWIDTH-1:0] awaddr;
    logic                 awvalid;
    logic                 awready;
    logic [2:0]           awprot;
    logic [DATAWIDTH-1:0] wdata;
    logic                 wvalid;
    logic                 wready;
    logic                 wlast;
`ifdef AXI4_MEM_RESPONDER_WSTRB_EN
    logic [DATAWIDTH/8-1:0] wstrb;
`endif
    logic                 bvalid;
    logic                 bready;
    logic [1:0]           bresp;
    logic [ADDRWIDTH-1:0] araddr;
    logic                 arvalid;
    logic                 arready;
    logic [2:0]           arprot;
    logic [DATAWIDTH-1:0] rdata;
    logic                 rvalid;
    logic                 rready;
    logic [1:0]           rresp;

`ifdef AXI4_MEM_RESPONDER_WSTRB_EN
    modport slave (
        input  awaddr, awvalid, awprot, wdata, wvalid, wlast, wstrb, bready,
        input  araddr, arvalid, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rdata, rvalid, rresp
    );
    modport master (
        output awaddr, awvalid, awprot, wdata, wvalid, wlast, wstrb, bready,
        output araddr, arvalid, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rdata, rvalid, rresp
    );
`else
    modport slave (
        input  awaddr, awvalid, awprot, wdata, wvalid, wlast, bready,
        input  araddr, arvalid, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rdata, rvalid, rresp
    );
    modport master (
        output awaddr, awvalid, awprot, wdata, wvalid, wlast, bready,
        output araddr, arvalid, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rdata, rvalid, rresp
    );
`endif

endinterface

// File: rtl/axi4_wait_ctr.sv
// Per-channel ready generator: ready rises once valid has been seen WAIT cycles with the slot empty.
module axi4_wait_ctr
    import axi4_bfm_pkg::*;
#(
    parameter int unsigned WAIT = 0
) (
    input  logic clk,
    input  logic nreset,
    input  logic valid,
    input  logic slot_empty,
    output logic ready
);
    localparam int unsigned CntW = clog2(WAIT + 2);

    logic [CntW-1:0] r_cnt;

    assign ready = slot_empty && (r_cnt == CntW'(WAIT));

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_cnt <= '0;
        end else if (!valid || ready) begin
            r_cnt <= '0;
        end else if (slot_empty && (r_cnt != CntW'(WAIT))) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/axi4_mem_responder.sv
// AXI4-Lite responder backed by a word-addressed memory, with wait states and read latency.
// AXI4_MEM_RESPONDER_WSTRB_EN enables per-byte-lane write strobes.
module axi4_mem_responder
    import axi4_bfm_pkg::*;
#(
    parameter int unsigned ADDRWIDTH     = 32,
    parameter int unsigned DATAWIDTH     = 32,
    parameter int unsigned MEMDEPTH_LOG2 = 10,
    parameter int unsigned WR_WAIT       = 0,
    parameter int unsigned RD_WAIT       = 0,
    parameter int unsigned RD_LATENCY    = 1
) (
    input logic                  clk,
    input logic                  nreset,
    axi4_mem_responder_if.slave  bus
);
    localparam int unsigned ByteW = clog2(DATAWIDTH / 8);
    localparam int unsigned Depth = 1 << MEMDEPTH_LOG2;
    localparam int unsigned LatW  = clog2(RD_LATENCY + 1);

    function automatic logic [MEMDEPTH_LOG2-1:0] word_idx(input logic [ADDRWIDTH-1:0] a);
        return a[ByteW +: MEMDEPTH_LOG2];
    endfunction

    function automatic logic out_of_range(input logic [ADDRWIDTH-1:0] a);
        return (a >> (ByteW + MEMDEPTH_LOG2)) != '0;
    endfunction

    logic                     r_active;
    wr_state_e                r_wstate, w_wstate_next;
    rd_state_e                r_rstate, w_rstate_next;
    logic                     r_aw_full, r_w_full, r_aw_oor, r_ar_oor;
    logic [MEMDEPTH_LOG2-1:0] r_aw_idx, r_ar_idx;
    logic [DATAWIDTH-1:0]     r_wdata, r_rdata;
    logic [DATAWIDTH-1:0]     r_mem [Depth];
    logic [1:0]               r_bresp, r_rresp;
    logic [LatW-1:0]          r_lat;
    logic                     w_aw_hs, w_w_hs, w_ar_hs, w_wr_commit, w_rd_sample;
    logic                     w_aw_empty, w_w_empty, w_ar_empty, w_wr_oor, w_rd_oor;
    logic [MEMDEPTH_LOG2-1:0] w_wr_idx, w_rd_idx;
    logic [DATAWIDTH-1:0]     w_wr_data;
    logic                     w_unused;
`ifdef AXI4_MEM_RESPONDER_WSTRB_EN
    logic [DATAWIDTH/8-1:0]   r_wstrb, w_wr_strb;
`endif

    assign w_unused = ^{bus.awprot, bus.wlast, bus.arprot, bus.awaddr, bus.araddr};

    // Holds every ready low while reset is asserted and for the first cycle after release.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) r_active <= 1'b0;
        else         r_active <= 1'b1;
    end

    assign w_aw_empty = r_active && (r_wstate != W_RESP) && !r_aw_full;
    assign w_w_empty  = r_active && (r_wstate != W_RESP) && !r_w_full;
    assign w_ar_empty = r_active && (r_rstate == R_IDLE);

    axi4_wait_ctr #(.WAIT(WR_WAIT)) u_aw_wait (
        .clk(clk), .nreset(nreset), .valid(bus.awvalid), .slot_empty(w_aw_empty),
        .ready(bus.awready)
    );
    axi4_wait_ctr #(.WAIT(WR_WAIT)) u_w_wait (
        .clk(clk), .nreset(nreset), .valid(bus.wvalid), .slot_empty(w_w_empty),
        .ready(bus.wready)
    );
    axi4_wait_ctr #(.WAIT(RD_WAIT)) u_ar_wait (
        .clk(clk), .nreset(nreset), .valid(bus.arvalid), .slot_empty(w_ar_empty),
        .ready(bus.arready)
    );

    assign w_aw_hs = bus.awvalid && bus.awready;
    assign w_w_hs  = bus.wvalid && bus.wready;
    assign w_ar_hs = bus.arvalid && bus.arready;

    // A held slot wins over the bus; otherwise the handshake completing this edge supplies it.
    assign w_wr_idx    = r_aw_full ? r_aw_idx : word_idx(bus.awaddr);
    assign w_wr_oor    = r_aw_full ? r_aw_oor : out_of_range(bus.awaddr);
    assign w_wr_data   = r_w_full ? r_wdata : bus.wdata;
`ifdef AXI4_MEM_RESPONDER_WSTRB_EN
    assign w_wr_strb   = r_w_full ? r_wstrb : bus.wstrb;
`endif
    assign w_wr_commit = (r_wstate != W_RESP) && (r_aw_full || w_aw_hs) && (r_w_full || w_w_hs);

    always_comb begin
        w_wstate_next = r_wstate;
        unique case (r_wstate)
            W_IDLE: begin
                if (w_wr_commit)            w_wstate_next = W_RESP;
                else if (w_aw_hs || w_w_hs) w_wstate_next = W_COLLECT;
            end
            W_COLLECT: if (w_wr_commit) w_wstate_next = W_RESP;
            W_RESP:    if (bus.bready)  w_wstate_next = W_IDLE;
            default:   w_wstate_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_wstate  <= W_IDLE;
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_aw_idx  <= '0;
            r_aw_oor  <= 1'b0;
            r_wdata   <= '0;
            r_bresp   <= RESP_OKAY;
`ifdef AXI4_MEM_RESPONDER_WSTRB_EN
            r_wstrb   <= '0;
`endif
        end else begin
            r_wstate <= w_wstate_next;
            if (w_wr_commit) begin
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
                r_bresp   <= w_wr_oor ? RESP_SLVERR : RESP_OKAY;
            end else begin
                if (w_aw_hs) begin
                    r_aw_full <= 1'b1;
                    r_aw_idx  <= word_idx(bus.awaddr);
                    r_aw_oor  <= out_of_range(bus.awaddr);
                end
                if (w_w_hs) begin
                    r_w_full <= 1'b1;
                    r_wdata  <= bus.wdata;
`ifdef AXI4_MEM_RESPONDER_WSTRB_EN
                    r_wstrb  <= bus.wstrb;
`endif
                end
            end
        end
    end

    // Memory content survives reset.
    always_ff @(posedge clk) begin
        if (w_wr_commit && !w_wr_oor) begin
`ifdef AXI4_MEM_RESPONDER_WSTRB_EN
            for (int unsigned i = 0; i < DATAWIDTH / 8; i++) begin
                if (w_wr_strb[i]) r_mem[w_wr_idx][8*i +: 8] <= w_wr_data[8*i +: 8];
            end
`else
            r_mem[w_wr_idx] <= w_wr_data;
`endif
        end
    end

    assign bus.bvalid = (r_wstate == W_RESP);
    assign bus.bresp  = r_bresp;

    assign w_rd_idx    = (r_rstate == R_IDLE) ? word_idx(bus.araddr) : r_ar_idx;
    assign w_rd_oor    = (r_rstate == R_IDLE) ? out_of_range(bus.araddr) : r_ar_oor;
    // Latency 1 samples on the AR handshake edge itself; longer latencies count down in R_WAIT.
    assign w_rd_sample = ((r_rstate == R_IDLE) && w_ar_hs && (RD_LATENCY == 1)) ||
                         ((r_rstate == R_WAIT) && (r_lat == LatW'(1)));

    always_comb begin
        w_rstate_next = r_rstate;
        unique case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_next = (RD_LATENCY == 1) ? R_RESP : R_WAIT;
            R_WAIT:  if (w_rd_sample) w_rstate_next = R_RESP;
            R_RESP:  if (bus.rready) w_rstate_next = R_IDLE;
            default: w_rstate_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_rstate <= R_IDLE;
            r_ar_idx <= '0;
            r_ar_oor <= 1'b0;
            r_lat    <= '0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else begin
            r_rstate <= w_rstate_next;
            if ((r_rstate == R_IDLE) && w_ar_hs) begin
                r_ar_idx <= word_idx(bus.araddr);
                r_ar_oor <= out_of_range(bus.araddr);
                r_lat    <= LatW'(RD_LATENCY - 1);
            end else if ((r_rstate == R_WAIT) && !w_rd_sample) begin
                r_lat <= r_lat - 1'b1;
            end
            if (w_rd_sample) begin
                r_rdata <= w_rd_oor ? '0 : r_mem[w_rd_idx];
                r_rresp <= w_rd_oor ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    assign bus.rvalid = (r_rstate == R_RESP);
    assign bus.rdata  = r_rdata;
    assign bus.rresp  = r_rresp;

endmodule

// File: tb/tb_axi4_mem_responder.sv
// Bench: two responders (zero-wait and waited) checked against a word-array model.
module tb_axi4_mem_responder;
    import axi4_bfm_pkg::*;

`ifdef AXI4_MEM_RESPONDER_WSTRB_EN
    localparam bit STRB_EN = 1'b1;
`else
    localparam bit STRB_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    axi4_mem_responder_if #(.ADDRWIDTH(32), .DATAWIDTH(32)) b0 ();
    axi4_mem_responder_if #(.ADDRWIDTH(32), .DATAWIDTH(32)) b1 ();

    axi4_mem_responder #(
        .ADDRWIDTH(32), .DATAWIDTH(32), .MEMDEPTH_LOG2(10),
        .WR_WAIT(0), .RD_WAIT(0), .RD_LATENCY(1)
    ) dut0 (.clk(clk), .nreset(nreset), .bus(b0));

    axi4_mem_responder #(
        .ADDRWIDTH(32), .DATAWIDTH(32), .MEMDEPTH_LOG2(10),
        .WR_WAIT(2), .RD_WAIT(3), .RD_LATENCY(4)
    ) dut1 (.clk(clk), .nreset(nreset), .bus(b1));

    // Shared driver; sel steers the valids/readys to one responder and muxes its outputs back.
    bit          sel;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
`ifdef AXI4_MEM_RESPONDER_WSTRB_EN
    logic [3:0]  wstrb;
    assign b0.wstrb = wstrb;
    assign b1.wstrb = wstrb;
`endif

    assign b0.awaddr  = awaddr;            assign b1.awaddr  = awaddr;
    assign b0.wdata   = wdata;             assign b1.wdata   = wdata;
    assign b0.araddr  = araddr;            assign b1.araddr  = araddr;
    assign b0.awprot  = 3'b000;            assign b1.awprot  = 3'b000;
    assign b0.arprot  = 3'b000;            assign b1.arprot  = 3'b000;
    assign b0.wlast   = 1'b1;              assign b1.wlast   = 1'b1;
    assign b0.awvalid = awvalid & ~sel;    assign b1.awvalid = awvalid & sel;
    assign b0.wvalid  = wvalid & ~sel;     assign b1.wvalid  = wvalid & sel;
    assign b0.bready  = bready & ~sel;     assign b1.bready  = bready & sel;
    assign b0.arvalid = arvalid & ~sel;    assign b1.arvalid = arvalid & sel;
    assign b0.rready  = rready & ~sel;     assign b1.rready  = rready & sel;

    assign awready = sel ? b1.awready : b0.awready;
    assign wready  = sel ? b1.wready  : b0.wready;
    assign bvalid  = sel ? b1.bvalid  : b0.bvalid;
    assign bresp   = sel ? b1.bresp   : b0.bresp;
    assign arready = sel ? b1.arready : b0.arready;
    assign rvalid  = sel ? b1.rvalid  : b0.rvalid;
    assign rresp   = sel ? b1.rresp   : b0.rresp;
    assign rdata   = sel ? b1.rdata   : b0.rdata;

    logic [31:0] mem [2][1024];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // 1024 words of 4 bytes: anything at or above 4 KiB is out of range.
    task automatic model_write(input int s, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] st, output logic [1:0] resp);
        if (a >= 32'h1000) begin
            resp = RESP_SLVERR;
        end else begin
            resp = RESP_OKAY;
            for (int i = 0; i < 4; i++)
                if (st[i] || !STRB_EN) mem[s][(a / 4) % 1024][8*i +: 8] = d[8*i +: 8];
        end
    endtask

    task automatic model_read(input int s, input logic [31:0] a, output logic [31:0] d,
                              output logic [1:0] resp);
        if (a >= 32'h1000) begin
            d = 32'h0;
            resp = RESP_SLVERR;
        end else begin
            d = mem[s][(a / 4) % 1024];
            resp = RESP_OKAY;
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                            input int awd, input int wd, input int bd, input string tag,
                            output int aw_lat);
        bit aw_done = 0;
        bit w_done = 0;
        int k = 0;
        logic [1:0] exp_resp, got_resp;
        aw_lat = -1;
        while (!(aw_done && w_done)) begin
            @(posedge clk); #1;
            awaddr = a;
            wdata = d;
`ifdef AXI4_MEM_RESPONDER_WSTRB_EN
            wstrb = st;
`endif
            awvalid = !aw_done && (k >= awd);
            wvalid = !w_done && (k >= wd);
            #1;
            if (awvalid && awready) begin
                aw_done = 1;
                aw_lat = k - awd;
            end
            if (wvalid && wready) w_done = 1;
            k++;
            if (k > 60) begin
                check({tag, "_hs_timeout"}, 64'(k), 64'd0);
                aw_done = 1;
                w_done = 1;
            end
        end
        model_write(int'(sel), a, d, st, exp_resp);
        @(posedge clk); #1;
        awvalid = 0;
        wvalid = 0;
        #1;
        check({tag, "_bvalid"}, 64'(bvalid), 64'd1);
        got_resp = bresp;
        for (int i = 0; i < bd; i++) begin
            @(posedge clk); #2;
            check({tag, "_bhold"}, {bvalid, bresp, awready, wready}, {1'b1, got_resp, 2'b00});
        end
        bready = 1;
        #1;
        check({tag, "_bresp"}, 64'(bresp), 64'(exp_resp));
        @(posedge clk); #1;
        bready = 0;
        #1;
        check({tag, "_bonce"}, 64'(bvalid), 64'd0);
    endtask

    task automatic do_read(input logic [31:0] a, input int ard, input int rd, input string tag,
                           output int ar_lat, output int r_lat);
        bit done = 0;
        int k = 0;
        logic [31:0] exp_d;
        logic [1:0] exp_r;
        logic [33:0] got;
        ar_lat = -1;
        r_lat = -1;
        while (!done) begin
            @(posedge clk); #1;
            araddr = a;
            arvalid = (k >= ard);
            #1;
            if (arvalid && arready) begin
                done = 1;
                ar_lat = k - ard;
            end
            k++;
            if (k > 60) begin
                check({tag, "_ar_timeout"}, 64'(k), 64'd0);
                done = 1;
            end
        end
        model_read(int'(sel), a, exp_d, exp_r);
        for (int j = 1; j <= 20 && r_lat < 0; j++) begin
            @(posedge clk); #1;
            arvalid = 0;
            #1;
            if (rvalid) r_lat = j;
        end
        check({tag, "_rvalid"}, 64'(rvalid), 64'd1);
        got = {rresp, rdata};
        for (int i = 0; i < rd; i++) begin
            @(posedge clk); #2;
            check({tag, "_rhold"}, {rvalid, rresp, rdata, arready}, {1'b1, got, 1'b0});
        end
        rready = 1;
        #1;
        check({tag, "_rdata"}, {rresp, rdata}, {exp_r, exp_d});
        @(posedge clk); #1;
        rready = 0;
        #1;
        check({tag, "_ronce"}, 64'(rvalid), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int al, rl, g;
        logic [31:0] a, d;
        logic [3:0] st;
        sel = 0;
        awaddr = 0; wdata = 0; araddr = 0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
`ifdef AXI4_MEM_RESPONDER_WSTRB_EN
        wstrb = 4'h0;
`endif
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 1024; i++) mem[s][i] = 32'h0;

        repeat (3) @(posedge clk);
        #2;
        check("rst_dut0", {b0.awready, b0.wready, b0.arready, b0.bvalid, b0.rvalid,
                           b0.bresp, b0.rresp, b0.rdata}, 64'd0);
        check("rst_dut1", {b1.awready, b1.wready, b1.arready, b1.bvalid, b1.rvalid,
                           b1.bresp, b1.rresp, b1.rdata}, 64'd0);
        @(posedge clk); #1;
        nreset = 1;

        // Give every word the random traffic touches a known value.
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int i = 0; i < 16; i++) do_write(32'(i * 4), $urandom, 4'hf, 0, 0, 0, "fill", al);
        end

        sel = 0;
        do_write(32'h10, 32'hDEADBEEF, 4'hf, 0, 0, 0, "wr10", al);
        do_read(32'h10, 0, 0, "rd10", al, rl);
        check("rd10_latency", 64'(rl), 64'd1);

        do_write(32'h0, 32'h1111_1111, 4'hf, 3, 0, 0, "ord_w_first", al);
        do_write(32'h4, 32'h2222_2222, 4'hf, 0, 2, 0, "ord_aw_first", al);
        do_write(32'h8, 32'h3333_3333, 4'hf, 0, 0, 1, "ord_both", al);
        do_read(32'h0, 0, 0, "ord_rd0", al, rl);
        do_read(32'h4, 0, 0, "ord_rd4", al, rl);
        do_read(32'h8, 0, 0, "ord_rd8", al, rl);

        do_write(32'h14, 32'h5A5A_0F0F, 4'hf, 0, 0, 5, "bp_w0", al);
        do_read(32'h14, 0, 5, "bp_r0", al, rl);

        do_write(32'h1000, 32'hCAFE_F00D, 4'hf, 0, 0, 0, "oor_w", al);
        do_read(32'h1000, 0, 0, "oor_r", al, rl);
        do_read(32'h0, 0, 0, "oor_word0", al, rl);

        sel = 1;
        do_write(32'h20, 32'h1234_5678, 4'hf, 0, 0, 0, "wait_w", al);
        check("aw_wait_cycles", 64'(al), 64'd2);
        do_read(32'h20, 0, 0, "wait_r", al, rl);
        check("ar_wait_cycles", 64'(al), 64'd3);
        check("rd_latency4", 64'(rl), 64'd4);
        do_write(32'h10, 32'hDEADBEEF, 4'hf, 0, 0, 5, "bp_w1", al);
        do_read(32'h10, 0, 5, "bp_r1", al, rl);

        // Reset lands while dut1 is counting down its read latency.
        araddr = 32'h10;
        @(posedge clk); #1;
        arvalid = 1;
        #1;
        g = 0;
        while (!arready && g < 20) begin
            @(posedge clk); #2;
            g++;
        end
        check("rst_ar_hs", 64'(arready), 64'd1);
        @(posedge clk); #1;
        arvalid = 0;
        @(posedge clk); #1;
        nreset = 0;
        #1;
        check("rst_mid_outputs", {rvalid, arready, b1.rdata}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        nreset = 1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #2;
            check("rst_no_resp", 64'(rvalid), 64'd0);
        end
        do_read(32'h10, 0, 0, "rst_reread", al, rl);

`ifdef AXI4_MEM_RESPONDER_WSTRB_EN
        sel = 0;
        do_write(32'h10, 32'hAAAA_5555, 4'b0011, 0, 0, 0, "strb_w", al);
        do_read(32'h10, 0, 0, "strb_r", al, rl);
        check("strb_model", 64'(mem[0][4]), 64'h0000_0000_DEAD_5555);
        do_write(32'h10, 32'h1234_5678, 4'b0000, 0, 0, 0, "strb0_w", al);
        do_read(32'h10, 0, 0, "strb0_r", al, rl);
`endif

        for (int n = 0; n < 60; n++) begin
            sel = 1'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a | (32'h1000 << $urandom_range(0, 19));
            d = $urandom;
            st = STRB_EN ? 4'($urandom_range(0, 15)) : 4'hf;
            if ($urandom_range(0, 1) == 1)
                do_write(a, d, st, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)), "rand_w", al);
            else
                do_read(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), "rand_r",
                        al, rl);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
